// File: rtl/deser6_pkg.sv
// Shared types and defaults for the 6-bit LSB-first serial frame receiver.
package deser6_pkg;

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int         DEF_W         = 6;
  localparam logic [5:0] DEF_SYNC_WORD = 6'b101101;
  localparam int         DEF_FRAME_LEN = 4;
  localparam int         DEF_MISS_MAX  = 2;

  // Compares only the low 'width' bits so any word width up to 32 can share it.
  function automatic logic sync_match(input logic [31:0] window,
                                      input logic [31:0] pattern,
                                      input int unsigned width);
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return ((window ^ pattern) & mask) == 32'd0;
  endfunction

endpackage

// File: rtl/sipo_shreg.sv
// LSB-first serial-in shift register; new bits enter at the MSB so that after
// W shifts bit 0 holds the first bit received.
module sipo_shreg #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         din_i,
  output logic [W-1:0] window_o,
  output logic [W-1:0] window_next_o
);

  logic [W-1:0] sreg_q;
  logic [W-1:0] sreg_d;

  assign sreg_d        = {din_i, sreg_q[W-1:1]};
  assign window_o      = sreg_q;
  assign window_next_o = sreg_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

endmodule

// File: rtl/deser6_frame_rx.sv
// Frame receiver: hunts for the sync word at any bit offset, then tracks word
// and frame position, emitting data words and dropping lock on repeated misses.
module deser6_frame_rx
  import deser6_pkg::*;
#(
  parameter int           W         = DEF_W,
  parameter logic [W-1:0] SYNC_WORD = W'(DEF_SYNC_WORD),
  parameter int           FRAME_LEN = DEF_FRAME_LEN,
  parameter int           MISS_MAX  = DEF_MISS_MAX
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         din,
  output logic [W-1:0] pout,
  output logic         pout_valid,
  output logic         locked,
  output logic         sync_err
);

  localparam int BIT_W  = (W > 1) ? $clog2(W) : 1;
  localparam int WORD_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int MISS_W = $clog2(MISS_MAX + 1);
  localparam int FILL_W = $clog2(W + 1);

  logic [W-1:0] window_q;
  logic [W-1:0] window_next;
  logic         unused_window_lsb;
  logic         window_is_sync;

  sipo_shreg #(.W(W)) u_sipo (
    .clk          (clk),
    .rst_n        (rst_n),
    .din_i        (din),
    .window_o     (window_q),
    .window_next_o(window_next)
  );

  // Decisions use the post-shift window; the registered copy is informational.
  assign unused_window_lsb = ^window_q;
  assign window_is_sync    = sync_match(32'(window_next), 32'(SYNC_WORD), W);

  state_e              state_q, state_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0]   word_cnt_q, word_cnt_d;
  logic [MISS_W-1:0]   miss_cnt_q, miss_cnt_d;
  logic [W-1:0]        pout_q, pout_d;
  logic                pout_valid_q, pout_valid_d;
  logic                sync_err_q, sync_err_d;

  always_comb begin
    state_d      = state_q;
    fill_d       = fill_q;
    bit_cnt_d    = bit_cnt_q;
    word_cnt_d   = word_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    pout_d       = pout_q;
    pout_valid_d = 1'b0;
    sync_err_d   = 1'b0;

    case (state_q)
      HUNT: begin
        if (fill_q != FILL_W'(W)) begin
          fill_d = fill_q + FILL_W'(1);
        end
        // The window is complete once this edge shifts in the W-th fresh bit.
        if ((fill_q >= FILL_W'(W - 1)) && window_is_sync) begin
          state_d    = LOCKED;
          bit_cnt_d  = '0;
          word_cnt_d = WORD_W'(1);
          miss_cnt_d = '0;
        end
      end

      LOCKED: begin
        if (bit_cnt_q == BIT_W'(W - 1)) begin
          bit_cnt_d  = '0;
          word_cnt_d = (word_cnt_q == WORD_W'(FRAME_LEN - 1)) ? '0 : word_cnt_q + WORD_W'(1);
          if (word_cnt_q != '0) begin
            pout_d       = window_next;
            pout_valid_d = 1'b1;
          end else if (window_is_sync) begin
            miss_cnt_d = '0;
          end else begin
            sync_err_d = 1'b1;
            miss_cnt_d = miss_cnt_q + MISS_W'(1);
            if ((miss_cnt_q + MISS_W'(1)) == MISS_W'(MISS_MAX)) begin
              state_d = HUNT;
              fill_d  = '0;
            end
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end

      default: begin
        state_d = HUNT;
        fill_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      fill_q       <= '0;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      miss_cnt_q   <= '0;
      pout_q       <= '0;
      pout_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_q       <= fill_d;
      bit_cnt_q    <= bit_cnt_d;
      word_cnt_q   <= word_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      pout_q       <= pout_d;
      pout_valid_q <= pout_valid_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign pout       = pout_q;
  assign pout_valid = pout_valid_q;
  assign locked     = (state_q == LOCKED);
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_deser6_frame_rx.sv
// Directed bench for deser6_frame_rx: word-level vector table plus hand-written
// sequences for bit-offset hunting and mid-word reset.
module tb_deser6_frame_rx;

  logic       clk;
  logic       rst_n;
  logic       din;
  logic [5:0] pout;
  logic       pout_valid;
  logic       locked;
  logic       sync_err;

  int n_cmp = 0;
  int n_bad = 0;

  deser6_frame_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .pout      (pout),
    .pout_valid(pout_valid),
    .locked    (locked),
    .sync_err  (sync_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [5:0] w;   // word sent LSB first
    logic       ev;  // expected pout_valid after last bit
    logic [5:0] ep;  // expected pout after last bit
    logic       el;  // expected locked after last bit
    logic       ee;  // expected sync_err after last bit
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [5:0] w, input logic ev, input logic [5:0] ep,
                              input logic el, input logic ee);
    vec_t v;
    v.w = w; v.ev = ev; v.ep = ep; v.el = el; v.ee = ee;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    rst_n = 1'b0;
    din   = 1'b0;
    @(posedge clk);
    #1;
    chk({nm, " pout"},  pout, 6'h00);
    chk({nm, " valid"}, 6'(pout_valid), 6'h00);
    chk({nm, " locked"}, 6'(locked), 6'h00);
    chk({nm, " err"},   6'(sync_err), 6'h00);
    rst_n = 1'b1;
    $display("reset %s: pout=%h valid=%b locked=%b err=%b", nm, pout, pout_valid, locked, sync_err);
  endtask

  // Sends bits lo..hi of w; strobes must stay low until the last bit lands.
  task automatic send(input logic [5:0] w, input int lo, input int hi, input logic ev,
                      input logic [5:0] ep, input logic el, input logic ee, input string nm);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      din = w[i];
      @(posedge clk);
      #1;
      if (i < hi) begin
        chk({nm, " mid valid"}, 6'(pout_valid), 6'h00);
        chk({nm, " mid err"},   6'(sync_err), 6'h00);
      end
    end
    chk({nm, " valid"},  6'(pout_valid), 6'(ev));
    chk({nm, " pout"},   pout, ep);
    chk({nm, " locked"}, 6'(locked), 6'(el));
    chk({nm, " err"},    6'(sync_err), 6'(ee));
    $display("%s: sent %h bits %0d..%0d -> pout=%h valid=%b locked=%b err=%b",
             nm, w, lo, hi, pout, pout_valid, locked, sync_err);
  endtask

  initial begin
    rst_n = 1'b0;
    din   = 1'b0;

    // Lock, data, single misses, data equal to sync, double miss, relock.
    tbl.push_back(mk(6'h2D, 0, 6'h00, 1, 0));
    tbl.push_back(mk(6'h01, 1, 6'h01, 1, 0));
    tbl.push_back(mk(6'h3F, 1, 6'h3F, 1, 0));
    tbl.push_back(mk(6'h15, 1, 6'h15, 1, 0));
    tbl.push_back(mk(6'h2D, 0, 6'h15, 1, 0));
    tbl.push_back(mk(6'h01, 1, 6'h01, 1, 0));
    tbl.push_back(mk(6'h3F, 1, 6'h3F, 1, 0));
    tbl.push_back(mk(6'h15, 1, 6'h15, 1, 0));
    tbl.push_back(mk(6'h2C, 0, 6'h15, 1, 1));
    tbl.push_back(mk(6'h01, 1, 6'h01, 1, 0));
    tbl.push_back(mk(6'h3F, 1, 6'h3F, 1, 0));
    tbl.push_back(mk(6'h15, 1, 6'h15, 1, 0));
    tbl.push_back(mk(6'h2D, 0, 6'h15, 1, 0));
    tbl.push_back(mk(6'h01, 1, 6'h01, 1, 0));
    tbl.push_back(mk(6'h3F, 1, 6'h3F, 1, 0));
    tbl.push_back(mk(6'h15, 1, 6'h15, 1, 0));
    tbl.push_back(mk(6'h2C, 0, 6'h15, 1, 1));
    tbl.push_back(mk(6'h01, 1, 6'h01, 1, 0));
    tbl.push_back(mk(6'h3F, 1, 6'h3F, 1, 0));
    tbl.push_back(mk(6'h15, 1, 6'h15, 1, 0));
    tbl.push_back(mk(6'h2D, 0, 6'h15, 1, 0));
    tbl.push_back(mk(6'h2D, 1, 6'h2D, 1, 0));
    tbl.push_back(mk(6'h3F, 1, 6'h3F, 1, 0));
    tbl.push_back(mk(6'h15, 1, 6'h15, 1, 0));
    tbl.push_back(mk(6'h2C, 0, 6'h15, 1, 1));
    tbl.push_back(mk(6'h01, 1, 6'h01, 1, 0));
    tbl.push_back(mk(6'h3F, 1, 6'h3F, 1, 0));
    tbl.push_back(mk(6'h15, 1, 6'h15, 1, 0));
    tbl.push_back(mk(6'h2C, 0, 6'h15, 0, 1));
    tbl.push_back(mk(6'h01, 0, 6'h15, 0, 0));
    tbl.push_back(mk(6'h3F, 0, 6'h15, 0, 0));
    tbl.push_back(mk(6'h15, 0, 6'h15, 0, 0));
    tbl.push_back(mk(6'h2D, 0, 6'h15, 1, 0));
    tbl.push_back(mk(6'h01, 1, 6'h01, 1, 0));
    tbl.push_back(mk(6'h3F, 1, 6'h3F, 1, 0));
    tbl.push_back(mk(6'h15, 1, 6'h15, 1, 0));

    do_reset("initial");
    for (int k = 0; k < tbl.size(); k++) begin
      send(tbl[k].w, 0, 5, tbl[k].ev, tbl[k].ep, tbl[k].el, tbl[k].ee, $sformatf("vec%0d", k));
    end

    // Reset mid data word while locked, then relock on the next sync.
    send(6'h2D, 0, 5, 0, 6'h15, 1, 0, "pre-rst sync");
    send(6'h01, 0, 2, 0, 6'h15, 1, 0, "pre-rst half");
    do_reset("midword");
    send(6'h01, 3, 5, 0, 6'h00, 0, 0, "post-rst rest");
    send(6'h3F, 0, 5, 0, 6'h00, 0, 0, "post-rst 3F");
    send(6'h15, 0, 5, 0, 6'h00, 0, 0, "post-rst 15");
    send(6'h2D, 0, 5, 0, 6'h00, 1, 0, "post-rst sync");
    send(6'h01, 0, 5, 1, 6'h01, 1, 0, "post-rst 01");

    // Three junk bits ahead of the stream: lock must land on the true boundary.
    do_reset("offset");
    send(6'h00, 0, 2, 0, 6'h00, 0, 0, "junk3");
    send(6'h2D, 0, 5, 0, 6'h00, 1, 0, "off sync");
    send(6'h01, 0, 5, 1, 6'h01, 1, 0, "off 01");
    send(6'h3F, 0, 5, 1, 6'h3F, 1, 0, "off 3F");
    send(6'h15, 0, 5, 1, 6'h15, 1, 0, "off 15");
    send(6'h2D, 0, 5, 0, 6'h15, 1, 0, "off sync2");
    send(6'h01, 0, 5, 1, 6'h01, 1, 0, "off 01b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
